freq_div_ctrl: RTL

//  Run-time controller for a divide-by-2*HALF clock generator: start/stop, burst of N

---
 rtl/freq_div_ctrl_pkg.sv | 9 +
 rtl/div_half_cnt.sv | 30 +++
 rtl/freq_div_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/freq_div_ctrl_pkg.sv
// Shared definitions for the freq_div_ctrl run-time clock divider controller.
// State encodings are fixed so legacy tooling and logs decode them unchanged.
package freq_div_ctrl_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_STOPPING = 2'd2;

endpackage

// File: rtl/div_half_cnt.sv
// Half-period counter: counts while enabled and pulses o_wrap on the last cycle
// of a level (count == half-1), restarting from zero on the following edge.
module div_half_cnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_half,
  output logic             o_wrap
);

  logic [WIDTH-1:0] r_count;
  logic             w_at_last;

  assign w_at_last = (r_count == (i_half - WIDTH'(1)));
  assign o_wrap    = i_en && w_at_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr || o_wrap) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/freq_div_ctrl.sv
// Run-time controller for a divide-by-2*half clock generator: start/stop,
// N-period bursts and glitch-free half-period reprogramming via a shadow register.
module freq_div_ctrl
  import freq_div_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned DEFAULT_HALF = 5,
  parameter int unsigned BURST_W      = 8
) (
  input  logic               CLK_IN,
  input  logic               RST_N,
  input  logic               START,
  input  logic               STOP,
  input  logic [BURST_W-1:0] BURST_LEN,
  input  logic               CFG_WE,
  input  logic [WIDTH-1:0]   CFG_HALF,
  output logic               CFG_ERR,
  output logic               CLK_OUT,
  output logic               TICK,
  output logic               BUSY,
  output logic               DONE
);

  logic [1:0]         r_state;
  logic               r_clk_out;
  logic               r_tick;
  logic               r_done;
  logic               r_cfg_err;
  logic [WIDTH-1:0]   r_half;
  logic [WIDTH-1:0]   r_shadow;
  logic               r_pend;
  logic [BURST_W-1:0] r_remain;

  logic w_idle;
  logic w_cnt_en;
  logic w_wrap;
  logic w_cfg_ok;
  logic w_apply;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_cnt_en = !w_idle;
  assign w_cfg_ok = CFG_WE && (CFG_HALF != '0);
  // Shadow reaches the live half-period only at a level boundary, or at once when idle.
  assign w_apply  = r_pend && (w_idle || w_wrap);

  div_half_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .i_clk   (CLK_IN),
    .i_rst_n (RST_N),
    .i_en    (w_cnt_en),
    .i_clr   (w_idle),
    .i_half  (r_half),
    .o_wrap  (w_wrap)
  );

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= ST_IDLE;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      r_half    <= WIDTH'(DEFAULT_HALF);
      r_shadow  <= WIDTH'(DEFAULT_HALF);
      r_pend    <= 1'b0;
      r_remain  <= '0;
    end else begin
      r_tick    <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= CFG_WE && !w_cfg_ok;
      if (w_cfg_ok) begin
        r_shadow <= CFG_HALF;
      end
      if (w_apply) begin
        r_half <= r_shadow;
      end
      r_pend <= w_cfg_ok || (r_pend && !w_apply);

      case (r_state)
        ST_IDLE: begin
          r_clk_out <= 1'b0;
          if (START && !STOP) begin
            r_state  <= ST_RUN;
            r_remain <= BURST_LEN;
          end
        end
        ST_RUN: begin
          if (w_wrap) begin
            // STOP on a boundary ends here: a fall completes the period, a rise is suppressed.
            if (STOP) begin
              r_state   <= ST_IDLE;
              r_clk_out <= 1'b0;
              r_done    <= 1'b1;
            end else if (!r_clk_out) begin
              r_clk_out <= 1'b1;
              r_tick    <= 1'b1;
            end else begin
              r_clk_out <= 1'b0;
              if (r_remain != '0) begin
                r_remain <= r_remain - BURST_W'(1);
                if (r_remain == BURST_W'(1)) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
                end
              end
            end
          end else if (STOP) begin
            r_state <= ST_STOPPING;
          end
        end
        ST_STOPPING: begin
          if (w_wrap) begin
            r_state   <= ST_IDLE;
            r_clk_out <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_clk_out <= 1'b0;
        end
      endcase
    end
  end

  assign CLK_OUT = r_clk_out;
  assign TICK    = r_tick;
  assign BUSY    = !w_idle;
  assign DONE    = r_done;
  assign CFG_ERR = r_cfg_err;

endmodule
